// File: rtl/rf_seq_pkg.sv
// rf_seq_pkg: shared types and constants for the block-transfer sequencer.
//   state_e    - sequencer state encoding
//   WORD_BYTES - address step per transferred register
//   PC_INDEX   - register index routed to the dedicated R15 write path
//   REG_COUNT  - number of architectural registers / reg_list width
package rf_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] PC_INDEX   = 4'd15;
    localparam int         REG_COUNT  = 16;

endpackage

// File: rtl/rf_list_pick.sv
// rf_list_pick: direction-selectable priority encoder over a register list.
//   list_i - remaining register list (bit i = Ri still to transfer)
//   up_i   - 1: pick lowest set bit, 0: pick highest set bit
//   idx_o  - picked register index (0 when list is empty)
//   vld_o  - list is non-empty
module rf_list_pick
    import rf_seq_pkg::*;
(
    input  logic [REG_COUNT-1:0] list_i,
    input  logic                 up_i,
    output logic [3:0]           idx_o,
    output logic                 vld_o
);

    always_comb begin
        idx_o = '0;
        vld_o = |list_i;
        if (up_i) begin
            // Scan downward so the last hit is the lowest set bit.
            for (int i = REG_COUNT - 1; i >= 0; i--) begin
                if (list_i[i]) idx_o = 4'(i);
            end
        end else begin
            // Scan upward so the last hit is the highest set bit.
            for (int i = 0; i < REG_COUNT; i++) begin
                if (list_i[i]) idx_o = 4'(i);
            end
        end
    end

endmodule

// File: rtl/rf_block_xfer_seq.sv
// rf_block_xfer_seq: block load/store sequencer for the 16x32 register file.
// Walks a 16-bit register list one register per memory access, holding the
// pipeline stalled through busy until the transfer completes.
//   clock, R         - clock, synchronous active-low reset
//   start ... base_addr - command (sampled only in IDLE)
//   busy, done, final_addr - status; final_addr holds until the next start
//   mem_*            - memory access handshake (ack may come in first cycle)
//   rf_rd_sel/rf_rd_data - RF read port 3 (combinational store data path)
//   rf_ld/rf_wsel/rf_wdata - RF general write port (R0..R14)
//   pc_we/pc_wdata   - dedicated R15 write path
module rf_block_xfer_seq
    import rf_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              R,
    input  logic              start,
    input  logic              is_load,
    input  logic              up,
    input  logic [15:0]       reg_list,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] final_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [3:0]        rf_rd_sel,
    input  logic [DATA_W-1:0] rf_rd_data,
    output logic              rf_ld,
    output logic [3:0]        rf_wsel,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pc_we,
    output logic [DATA_W-1:0] pc_wdata
);

    state_e                 state_q, state_d;
    logic [REG_COUNT-1:0]   list_q, list_d;
    logic                   ld_q, ld_d;
    logic                   up_q, up_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      data_q, data_d;
    logic [ADDR_W-1:0]      final_q, final_d;

    logic [3:0]             cur_idx;
    logic                   cur_vld;
    logic [REG_COUNT-1:0]   cur_bit;
    logic [REG_COUNT-1:0]   list_clr;
    logic [ADDR_W-1:0]      addr_step;

    rf_list_pick u_pick (
        .list_i (list_q),
        .up_i   (up_q),
        .idx_o  (cur_idx),
        .vld_o  (cur_vld)
    );

    always_comb begin
        cur_bit          = '0;
        cur_bit[cur_idx] = 1'b1;
    end

    assign list_clr   = list_q & ~cur_bit;
    // Address arithmetic wraps naturally modulo 2^ADDR_W.
    assign addr_step  = up_q ? addr_q + ADDR_W'(WORD_BYTES)
                             : addr_q - ADDR_W'(WORD_BYTES);
    assign final_addr = final_q;

    always_comb begin
        state_d   = state_q;
        list_d    = list_q;
        ld_d      = ld_q;
        up_d      = up_q;
        addr_d    = addr_q;
        data_d    = data_q;
        final_d   = final_q;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rf_rd_sel = '0;
        rf_ld     = 1'b0;
        rf_wsel   = '0;
        rf_wdata  = '0;
        pc_we     = 1'b0;
        pc_wdata  = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (reg_list != '0) begin
                        list_d  = reg_list;
                        ld_d    = is_load;
                        up_d    = up;
                        addr_d  = base_addr;
                        state_d = ACCESS;
                    end else begin
                        final_d = base_addr;
                        state_d = DONE;
                    end
                end
            end

            ACCESS: begin
                if (!cur_vld) begin
                    // Unreachable with a non-empty latched list; recover cleanly.
                    final_d = addr_q;
                    state_d = DONE;
                end else begin
                    mem_req   = 1'b1;
                    mem_we    = ~ld_q;
                    mem_addr  = addr_q;
                    rf_rd_sel = cur_idx;
                    mem_wdata = rf_rd_data;
                    if (mem_ack) begin
                        if (ld_q) begin
                            data_d  = mem_rdata;
                            state_d = WRITE;
                        end else begin
                            list_d = list_clr;
                            addr_d = addr_step;
                            if (list_clr == '0) begin
                                final_d = addr_step;
                                state_d = DONE;
                            end
                        end
                    end
                end
            end

            WRITE: begin
                if (cur_idx == PC_INDEX) begin
                    pc_we    = 1'b1;
                    pc_wdata = data_q;
                end else begin
                    rf_ld    = 1'b1;
                    rf_wsel  = cur_idx;
                    rf_wdata = data_q;
                end
                list_d = list_clr;
                addr_d = addr_step;
                if (list_clr == '0) begin
                    final_d = addr_step;
                    state_d = DONE;
                end else begin
                    state_d = ACCESS;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!R) begin
            state_q <= IDLE;
            list_q  <= '0;
            ld_q    <= 1'b0;
            up_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            final_q <= '0;
        end else begin
            state_q <= state_d;
            list_q  <= list_d;
            ld_q    <= ld_d;
            up_q    <= up_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            final_q <= final_d;
        end
    end

endmodule

// File: doc/rf_block_xfer_seq.md
# rf_block_xfer_seq

Multi-register transfer sequencer for the 16x32 register file. It takes one block load/store command with a 16-bit register list and walks the list one register per memory access. It drives the register file's third read port for stores, the general write port for loads, and the dedicated R15 write path when R15 is loaded. It sits beside the EX/MEM stages and holds the pipeline stalled through `busy` until the transfer finishes.

## Interface
Parameters:
- DATA_W, 32, register and memory data width
- ADDR_W, 32, byte address width

Ports:
- clock  in  1  single clock; all state changes on its rising edge
- R  in  1  reset, synchronous, active-low
- start  in  1  command strobe; sampled only in IDLE
- is_load  in  1  1 = memory-to-registers, 0 = registers-to-memory
- up  in  1  1 = ascending registers and addresses, 0 = descending
- reg_list  in  16  bit i set = transfer Ri
- base_addr  in  ADDR_W  first access address
- busy  out  1  high in every state except IDLE; used as the pipeline stall
- done  out  1  one-cycle completion pulse
- final_addr  out  ADDR_W  address after the last access; valid while done=1, holds until next start
- mem_req  out  1  access request
- mem_we  out  1  1 = write, valid with mem_req
- mem_addr  out  ADDR_W  valid with mem_req
- mem_wdata  out  DATA_W  store data, valid with mem_req and mem_we
- mem_ack  in  1  access complete; rdata valid this cycle for a read
- mem_rdata  in  DATA_W  load data
- rf_rd_sel  out  4  register file read select, port 3
- rf_rd_data  in  DATA_W  register file read data, port 3, combinational
- rf_ld  out  1  register file write enable
- rf_wsel  out  4  register file write select
- rf_wdata  out  DATA_W  register file write data
- pc_we  out  1  R15 write enable
- pc_wdata  out  DATA_W  R15 write data

## Operation
- States: IDLE, ACCESS, WRITE, DONE.
- Current register: the lowest set bit of the remaining list when up=1, the highest set bit when up=0. The address steps by +4 when up=1 and by -4 when up=0, wrapping modulo 2^ADDR_W.
- IDLE:
  - start=1 with reg_list≠0: latch the list, is_load, up and base_addr, then go to ACCESS.
  - start=1 with reg_list=0: go to DONE with final_addr=base_addr and make no access.
  - start=0: stay in IDLE.
- ACCESS:
  - Outputs: mem_req=1, mem_we=~is_load, mem_addr=current address, rf_rd_sel=current register, mem_wdata=rf_rd_data.
  - mem_req, mem_addr and mem_we stay stable until mem_ack.
  - On mem_ack for a load: capture mem_rdata and go to WRITE.
  - On mem_ack for a store: clear the current bit and step the address. Go to DONE if the list is now empty; otherwise stay in ACCESS.
- WRITE (one cycle):
  - Current register 0–14: rf_ld=1, rf_wsel=current register, rf_wdata=captured data.
  - Current register 15: pc_we=1, pc_wdata=captured data, rf_ld=0.
  - Then clear the current bit, step the address, and go to DONE if the list is empty, otherwise back to ACCESS.
- DONE (one cycle): done=1, final_addr updated, then go to IDLE.
- start while busy=1 is ignored; no queueing.
- mem_ack outside ACCESS is ignored.

## Timing
- Reset (R=0 at a rising edge):
  - state=IDLE.
  - busy, done, mem_req, mem_we, rf_ld and pc_we are 0.
  - mem_addr, mem_wdata, rf_wsel, rf_wdata, pc_wdata, rf_rd_sel and final_addr are 0.
  - Reset during a transfer aborts it: no further rf_ld or pc_we pulses, and the partial register updates remain.
- busy rises the cycle after start is accepted and falls the cycle after DONE.
- mem_ack may arrive in the first cycle of mem_req (zero-wait).
- Zero-wait latency, n registers:
  - store: n ACCESS cycles + 1 DONE cycle.
  - load: 2n cycles (ACCESS/WRITE pairs) + 1 DONE cycle.
  - start to done pulse: store n+1 cycles, load 2n+1 cycles.
- Each wait cycle (mem_req=1, mem_ack=0) adds exactly one cycle.
- rf_ld and pc_we are single-cycle pulses and are never asserted together.
- mem_wdata depends combinationally on rf_rd_data. The register file read path must settle within the cycle.

## Structure
- Package rf_seq_pkg holds:
  - the state enum {IDLE, ACCESS, WRITE, DONE}
  - WORD_BYTES=4
  - PC_INDEX=4'd15
  - REG_COUNT=16
- Sub-module rf_list_pick: combinational direction-selectable priority encoder. Inputs: 16-bit list and up. Outputs: 4-bit index and a valid/empty flag. It is instantiated once for the remaining list.

## Test plan
- Store, up=1, reg_list=16'h0026, base=0x100, ack every cycle:
  - accesses R1@0x100, R2@0x104, R5@0x108, each with mem_we=1 and data = register contents.
  - done on cycle 4; final_addr=0x10C.
- Load, up=0, reg_list=16'h8003, base=0x200, rdata=0xAAAA0000+addr:
  - order R15@0x200 (pc_we=1, pc_wdata=0xAAAA0200, rf_ld=0), then R1@0x1FC, then R0@0x1F8.
  - rf_ld pulses carry rf_wsel=1 and rf_wsel=0.
  - final_addr=0x1F4.
- Load of R3 with mem_ack held low 3 cycles:
  - mem_req/mem_addr stay stable for 4 cycles.
  - exactly one rf_ld pulse follows; done arrives 6 cycles after start.
- start with reg_list=0, base=0x40:
  - no mem_req; done the next cycle with final_addr=0x40; busy high for 1 cycle.
- Address wrap: store R0,R1, up=1, base=0xFFFFFFFC:
  - addresses 0xFFFFFFFC then 0x00000000; final_addr=0x4.
- Reset mid-load after the first WRITE of reg_list=16'h000F:
  - all outputs 0 the next cycle; only R0 is updated.
  - a start pulse issued while busy=1 earlier in the transfer is ignored.
